// File: rtl/data_memory_ctrl_if.sv
// Request/response bundle between the EX_MEM stage (master) and the data memory (slave).
interface data_memory_ctrl_if;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [31:0] MEM_ADDRESS;
    logic [31:0] MEM_WRITE_DATA;
    logic [2:0]  FUNC3;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT;

    modport master (
        output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA, FUNC3,
        input  READ_DATA, BUSYWAIT
    );

    modport slave (
        input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA, FUNC3,
        output READ_DATA, BUSYWAIT
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Word-organised data memory with a fixed multi-cycle access. Requests are
// latched in IDLE, the array is touched once the BUSY countdown expires, and a
// single DONE cycle with BUSYWAIT low lets the pipeline advance.
module data_memory_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    data_memory_ctrl_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [3:0]         r_counter;
    logic [IDX_W+1:0]   r_addr;
    logic [31:0]        r_wdata;
    logic [2:0]         r_func3;
    logic               r_is_write;
    logic [31:0]        r_read_data;
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic               w_req;
    logic               w_busywait;
    logic [IDX_W-1:0]   w_idx;
    logic [31:0]        w_word;
    logic               w_unused_addr;

    // Select the addressed byte/half of a word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b100:  res = {24'h000000, b};
            3'b101:  res = {16'h0000, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Merge store data into the old word, leaving unwritten lanes intact.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] data,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [31:0] res;
        res = old;
        case (f3)
            3'b000: begin
                case (off)
                    2'd0:    res[7:0]   = data[7:0];
                    2'd1:    res[15:8]  = data[7:0];
                    2'd2:    res[23:16] = data[7:0];
                    2'd3:    res[31:24] = data[7:0];
                    default: res[7:0]   = data[7:0];
                endcase
            end
            3'b001: begin
                if (off[1]) begin
                    res[31:16] = data[15:0];
                end else begin
                    res[15:0]  = data[15:0];
                end
            end
            default: res = data;
        endcase
        return res;
    endfunction

    assign w_req         = bus.MEM_READ | bus.MEM_WRITE;
    assign w_idx         = r_addr[IDX_W+1:2];
    assign w_word        = r_mem[w_idx];
    // Upper address bits are deliberately dropped so the address space wraps.
    assign w_unused_addr = ^bus.MEM_ADDRESS[31:IDX_W+2];

    // Access sequencer: latch request, count down latency, perform access, release.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_counter   <= 4'd0;
            r_addr      <= '0;
            r_wdata     <= 32'h0000_0000;
            r_func3     <= 3'b000;
            r_is_write  <= 1'b0;
            r_read_data <= 32'h0000_0000;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= 32'h0000_0000;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr     <= bus.MEM_ADDRESS[IDX_W+1:0];
                        r_wdata    <= bus.MEM_WRITE_DATA;
                        r_func3    <= bus.FUNC3;
                        r_is_write <= bus.MEM_WRITE;
                        r_counter  <= 4'(LATENCY - 1);
                        r_state    <= S_BUSY;
                    end else begin
                        r_state    <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (r_counter != 4'd0) begin
                        r_counter <= r_counter - 4'd1;
                    end else begin
                        if (r_is_write) begin
                            r_mem[w_idx] <= store_merge(w_word, r_wdata, r_addr[1:0], r_func3);
                        end else begin
                            r_read_data  <= load_extract(w_word, r_addr[1:0], r_func3);
                        end
                        r_state <= S_DONE;
                    end
                end
                // The request is still asserted here but belongs to the finished access.
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stall request: immediate in IDLE so the first edge already holds the pipeline.
    always_comb begin
        w_busywait = 1'b0;
        case (r_state)
            S_IDLE:  w_busywait = w_req;
            S_BUSY:  w_busywait = 1'b1;
            S_DONE:  w_busywait = 1'b0;
            default: w_busywait = 1'b0;
        endcase
    end

    assign bus.BUSYWAIT  = w_busywait;
    assign bus.READ_DATA = r_read_data;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: stimulus pushes expected completions into
// a queue, a negedge monitor pops and checks READ_DATA and the stall length.
module tb_data_memory_ctrl;
    localparam int LAT = 4;

    typedef struct {
        logic [31:0] rd;
        int          run;
        int          id;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    data_memory_ctrl_if bus ();

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_rd = 32'h0;
    logic        prev_busy = 1'b0;
    int          run = 0;

    data_memory_ctrl #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Monitor: a falling BUSYWAIT marks a DONE cycle; compare against the queue head.
    always @(negedge CLK) begin
        exp_t e;
        if (RESET) begin
            prev_busy = 1'b0;
            run = 0;
        end else begin
            if (bus.BUSYWAIT) begin
                run = run + 1;
            end else if (prev_busy) begin
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_completion: got READ_DATA=%h with no access pending", bus.READ_DATA);
                end else begin
                    e = q.pop_front();
                    tests++;
                    if (bus.READ_DATA !== e.rd) begin
                        fails++;
                        $display("FAIL read_data[%0d]: got %h expected %h", e.id, bus.READ_DATA, e.rd);
                    end
                    tests++;
                    if (run != e.run) begin
                        fails++;
                        $display("FAIL busy_len[%0d]: got %0d expected %0d", e.id, run, e.run);
                    end
                end
                run = 0;
            end
            prev_busy = bus.BUSYWAIT;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_exp(input logic is_wr, input logic [31:0] exp_rd, input int id);
        exp_t e;
        if (!is_wr) last_rd = exp_rd;
        e.rd  = last_rd;
        e.run = LAT + 1;
        e.id  = id;
        q.push_back(e);
    endtask

    // Wait (bounded) until the DUT reaches its DONE cycle; optionally scramble
    // the request fields during BUSY to show they are latched.
    task automatic wait_done(input int id, input bit scramble);
        bit done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge CLK); #1;
            if (scramble && k == 0) begin
                bus.MEM_ADDRESS    = ~bus.MEM_ADDRESS;
                bus.MEM_WRITE_DATA = ~bus.MEM_WRITE_DATA;
                bus.FUNC3          = ~bus.FUNC3;
            end
            if (!bus.BUSYWAIT) done = 1'b1;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL timeout[%0d]: BUSYWAIT still %b after 40 cycles", id, bus.BUSYWAIT);
        end
    endtask

    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [2:0] f3,
                          input logic [31:0] exp_rd, input int id);
        push_exp(wr, exp_rd, id);
        @(posedge CLK); #1;
        bus.MEM_READ       = rd;
        bus.MEM_WRITE      = wr;
        bus.MEM_ADDRESS    = addr;
        bus.MEM_WRITE_DATA = data;
        bus.FUNC3          = f3;
        wait_done(id, 1'b1);
        bus.MEM_READ  = 1'b0;
        bus.MEM_WRITE = 1'b0;
    endtask

    initial begin
        bus.MEM_READ       = 1'b0;
        bus.MEM_WRITE      = 1'b0;
        bus.MEM_ADDRESS    = 32'h0;
        bus.MEM_WRITE_DATA = 32'h0;
        bus.FUNC3          = 3'b000;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        check("reset_busywait", {31'h0, bus.BUSYWAIT}, 32'h0);
        check("reset_read_data", bus.READ_DATA, 32'h0);

        // Basic word store/load
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1);
        access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 2);

        // Byte/half loads with sign and zero extension
        access(1'b0, 1'b1, 32'h20, 32'h8000F07F, 3'b010, 32'h0, 3);
        access(1'b1, 1'b0, 32'h20, 32'h0, 3'b000, 32'h0000007F, 4);
        access(1'b1, 1'b0, 32'h21, 32'h0, 3'b000, 32'hFFFFFFF0, 5);
        access(1'b1, 1'b0, 32'h21, 32'h0, 3'b100, 32'h000000F0, 6);
        access(1'b1, 1'b0, 32'h22, 32'h0, 3'b001, 32'hFFFF8000, 7);
        access(1'b1, 1'b0, 32'h22, 32'h0, 3'b101, 32'h00008000, 8);
        access(1'b1, 1'b0, 32'h23, 32'h0, 3'b000, 32'hFFFFFF80, 9);

        // Partial stores preserve other lanes
        access(1'b0, 1'b1, 32'h30, 32'h11223344, 3'b010, 32'h0, 10);
        access(1'b0, 1'b1, 32'h31, 32'h000000AA, 3'b000, 32'h0, 11);
        access(1'b1, 1'b0, 32'h30, 32'h0, 3'b010, 32'h1122AA44, 12);
        access(1'b0, 1'b1, 32'h32, 32'h0000BEEF, 3'b001, 32'h0, 13);
        access(1'b1, 1'b0, 32'h30, 32'h0, 3'b010, 32'hBEEFAA44, 14);
        // Misaligned word access and an undefined code both read the full word
        access(1'b1, 1'b0, 32'h33, 32'h0, 3'b011, 32'hBEEFAA44, 15);

        // Back-to-back loads with the request held across DONE
        push_exp(1'b0, 32'h00008000, 16);
        push_exp(1'b0, 32'h00008000, 17);
        @(posedge CLK); #1;
        bus.MEM_READ    = 1'b1;
        bus.MEM_ADDRESS = 32'h22;
        bus.FUNC3       = 3'b101;
        wait_done(16, 1'b0);
        @(posedge CLK); #1;
        check("b2b_restart_busywait", {31'h0, bus.BUSYWAIT}, 32'h1);
        wait_done(17, 1'b0);
        bus.MEM_READ = 1'b0;
        repeat (3) @(posedge CLK);
        #1 check("b2b_exact_two", q.size(), 32'd0);

        // Reset during the third BUSY cycle of a store
        @(posedge CLK); #1;
        bus.MEM_WRITE      = 1'b1;
        bus.MEM_ADDRESS    = 32'h40;
        bus.MEM_WRITE_DATA = 32'h12345678;
        bus.FUNC3          = 3'b010;
        repeat (3) begin @(posedge CLK); #1; end
        RESET = 1'b1;
        bus.MEM_WRITE = 1'b0;
        #1;
        check("abort_busywait", {31'h0, bus.BUSYWAIT}, 32'h0);
        check("abort_read_data", bus.READ_DATA, 32'h0);
        @(posedge CLK); #1 RESET = 1'b0;
        last_rd = 32'h0;
        access(1'b1, 1'b0, 32'h40, 32'h0, 3'b010, 32'h00000000, 18);
        access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 32'h00000000, 19);

        // Address wrap and write priority
        access(1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 32'h00000000, 20);
        access(1'b0, 1'b1, 32'h400, 32'h5, 3'b010, 32'h0, 21);
        access(1'b1, 1'b0, 32'h000, 32'h0, 3'b010, 32'h00000005, 22);
        access(1'b1, 1'b1, 32'h50, 32'h77, 3'b010, 32'h0, 23);
        access(1'b1, 1'b0, 32'h50, 32'h0, 3'b010, 32'h00000077, 24);

        repeat (4) @(posedge CLK);
        #1 check("queue_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
